// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared state type, default widths and header nonce insertion for the nonce sweeper
package miner_pkg;

  localparam int WORD_W       = 32;
  localparam int HASH_W       = 256;
  localparam int MAX_HDR_BITS = 2048;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ISSUE,
    WAIT,
    CHECK,
    EMIT
  } miner_state_t;

  // Header is right-aligned in the vector with word 0 highest; the nonce lands in the low 32 bits of its word.
  function automatic logic [MAX_HDR_BITS-1:0] insert_nonce(
    input logic [MAX_HDR_BITS-1:0] hdr,
    input int                      word_w,
    input int                      hdr_words,
    input int                      nonce_idx,
    input logic [31:0]             nonce
  );
    logic [MAX_HDR_BITS-1:0] r;
    r = hdr;
    r[(hdr_words-1-nonce_idx)*word_w +: 32] = nonce;
    return r;
  endfunction

endpackage

// File: rtl/miner_word_serializer.sv
// rtl/miner_word_serializer.sv - parallel-load, ready/valid word shifter emitting MSB word first with last flag
module miner_word_serializer #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        load,
  input  logic [N_WORDS*WORD_W-1:0]   load_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_last
);

  localparam int CNT_W = $clog2(N_WORDS);

  logic [N_WORDS*WORD_W-1:0] sreg;
  logic [CNT_W-1:0]          idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      idx       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      sreg      <= load_data;
      idx       <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (idx == CNT_W'(N_WORDS-1)) begin
        out_valid <= 1'b0;
      end else begin
        sreg <= sreg << WORD_W;
        idx  <= idx + 1'b1;
      end
    end
  end

  assign out_data = sreg[N_WORDS*WORD_W-1 -: WORD_W];
  assign out_last = out_valid && (idx == CNT_W'(N_WORDS-1));

endmodule

// File: rtl/miner_nonce_sweeper.sv
// rtl/miner_nonce_sweeper.sv - header loader, ranged nonce sweep and hit streamer around an external hash core
// Optional hash counter output enabled by MINER_STATS_EN.
module miner_nonce_sweeper
  import miner_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int HDR_WORDS = 20,
  parameter int NONCE_IDX = 19,
  parameter int HASH_W    = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        start,
  input  logic                        abort,
  input  logic [31:0]                 nonce_base,
  input  logic [31:0]                 nonce_limit,
  input  logic [HASH_W-1:0]           target,
  output logic                        core_start,
  output logic [HDR_WORDS*WORD_W-1:0] core_header,
  input  logic                        core_done,
  input  logic [HASH_W-1:0]           core_hash,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        exhausted
`ifdef MINER_STATS_EN
  ,
  output logic [31:0]                 hash_count
`endif
);

  localparam int OUT_WORDS = HASH_W / WORD_W;
  localparam int HDR_BITS  = HDR_WORDS * WORD_W;
  localparam int WCNT_W    = $clog2(HDR_WORDS + 1);

  miner_state_t        state;
  logic [WCNT_W-1:0]   wcnt;
  logic [HDR_BITS-1:0] hdr;
  logic [31:0]         nonce;
  logic [31:0]         limit_r;
  logic [HASH_W-1:0]   target_r;
  logic [HASH_W-1:0]   hash_r;
  logic                hit;
  logic                ser_load;
  logic                ser_done;

  assign hit      = (hash_r <= target_r);
  // Serializer loads in the CHECK cycle so the first word is valid as EMIT begins.
  assign ser_load = (state == CHECK) && hit && !abort;
  assign ser_done = out_valid && out_ready && out_last;
  assign busy     = (state == ISSUE) || (state == WAIT) || (state == CHECK) || (state == EMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      hdr         <= '0;
      nonce       <= '0;
      limit_r     <= '0;
      target_r    <= '0;
      hash_r      <= '0;
      core_start  <= 1'b0;
      core_header <= '0;
      exhausted   <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      exhausted  <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        wcnt     <= '0;
        in_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            in_ready <= 1'b1;
            if (in_valid && in_ready) begin
              hdr[(HDR_WORDS-1-int'(wcnt))*WORD_W +: WORD_W] <= in_data;
              wcnt <= wcnt + 1'b1;
              if (wcnt == WCNT_W'(HDR_WORDS-1)) begin
                state    <= ARMED;
                in_ready <= 1'b0;
              end
            end
          end
          ARMED: begin
            if (start) begin
              nonce    <= nonce_base;
              limit_r  <= nonce_limit;
              target_r <= target;
              state    <= ISSUE;
            end
          end
          ISSUE: begin
            core_header <= HDR_BITS'(insert_nonce(MAX_HDR_BITS'(hdr), WORD_W, HDR_WORDS, NONCE_IDX, nonce));
            core_start  <= 1'b1;
            state       <= WAIT;
          end
          WAIT: begin
            if (core_done) begin
              hash_r <= core_hash;
              state  <= CHECK;
            end
          end
          CHECK: begin
            if (hit) begin
              state <= EMIT;
            end else if (nonce == limit_r) begin
              exhausted <= 1'b1;
              wcnt      <= '0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              nonce <= nonce + 32'd1;
              state <= ISSUE;
            end
          end
          EMIT: begin
            if (ser_done) begin
              wcnt     <= '0;
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  miner_word_serializer #(
    .WORD_W  (WORD_W),
    .N_WORDS (OUT_WORDS + 1)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort),
    .load      (ser_load),
    .load_data ({WORD_W'(nonce), hash_r}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

`ifdef MINER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_count <= '0;
    end else if (!abort) begin
      if (state == ARMED && start) begin
        hash_count <= '0;
      end else if (state == WAIT && core_done && hash_count != 32'hFFFF_FFFF) begin
        hash_count <= hash_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_miner_nonce_sweeper.sv
// tb/tb_miner_nonce_sweeper.sv - directed self-checking bench for miner_nonce_sweeper with a fixed-latency core model
module tb_miner_nonce_sweeper;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [31:0]  nonce_base = '0;
  logic [31:0]  nonce_limit = '0;
  logic [255:0] target = '0;
  logic         core_start;
  logic [639:0] core_header;
  logic         core_done = 1'b0;
  logic [255:0] core_hash = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         exhausted;
`ifdef MINER_STATS_EN
  logic [31:0]  hash_count;
`endif

  int checks = 0;
  int failures = 0;

  bit           hit_all = 1'b0;
  bit           hit_sel = 1'b0;
  logic [31:0]  hit_nonce = '0;
  logic [255:0] hit_hash = '0;
  logic [255:0] miss_hash = '0;

  int           start_cnt = 0;
  int           exh_cnt = 0;
  int           ov_cnt = 0;
  int           pend = 0;
  logic [31:0]  cur_nonce = '0;
  logic [31:0]  hdr_w0 = '0;
  logic [31:0]  hdr_w18 = '0;
  logic [31:0]  nonce_log[$];
  logic [31:0]  got_data[16];
  logic         got_last[16];

  always #5 clk = ~clk;

  miner_nonce_sweeper dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .start       (start),
    .abort       (abort),
    .nonce_base  (nonce_base),
    .nonce_limit (nonce_limit),
    .target      (target),
    .core_start  (core_start),
    .core_header (core_header),
    .core_done   (core_done),
    .core_hash   (core_hash),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .exhausted   (exhausted)
`ifdef MINER_STATS_EN
    ,
    .hash_count  (hash_count)
`endif
  );

  function automatic logic [255:0] model_hash(input logic [31:0] n);
    if (hit_all || (hit_sel && n == hit_nonce)) return hit_hash;
    return miss_hash;
  endfunction

  // Hash core model: result strobe two negedges after core_start is seen.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done = 1'b1;
          core_hash = model_hash(cur_nonce);
        end
      end
      if (core_start) begin
        start_cnt++;
        cur_nonce = core_header[31:0];
        hdr_w0    = core_header[639:608];
        hdr_w18   = core_header[63:32];
        nonce_log.push_back(cur_nonce);
        pend = 2;
      end
      if (exhausted) exh_cnt++;
      if (out_valid) ov_cnt++;
    end
  end

  task automatic load_header(input int n, output bit ok);
    int w;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = i;
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) ok = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_sweep(input logic [31:0] b, input logic [31:0] l, input logic [255:0] t);
    @(negedge clk);
    nonce_base  = b;
    nonce_limit = l;
    target      = t;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input bit stall, output int n_hs, output int stab_err, output bit timed_out);
    logic [31:0] pd;
    logic        pl;
    bit          pstall;
    bit          done;
    int          k;
    pd = '0; pl = 1'b0; pstall = 1'b0; done = 1'b0; k = 0;
    n_hs = 0; stab_err = 0; timed_out = 1'b1;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      out_ready = stall ? (k % 3 == 0) : 1'b1;
      #1;
      if (out_valid) begin
        if (pstall && (out_data !== pd || out_last !== pl)) stab_err++;
        pd = out_data;
        pl = out_last;
        pstall = !out_ready;
        k++;
        if (out_ready) begin
          if (n_hs < 16) begin
            got_data[n_hs] = out_data;
            got_last[n_hs] = out_last;
          end
          n_hs++;
          if (out_last) begin
            done = 1'b1;
            timed_out = 1'b0;
          end
        end
      end else begin
        pstall = 1'b0;
      end
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) n_hs++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
    checks++; if (exhausted !== 1'b0) begin failures++; $display("FAIL reset_exhausted got=%b exp=0", exhausted); end
    checks++; if (core_header !== 640'd0) begin failures++; $display("FAIL reset_core_header got=%h exp=0", core_header[63:0]); end
`ifdef MINER_STATS_EN
    checks++; if (hash_count !== 32'd0) begin failures++; $display("FAIL reset_hash_count got=%0d exp=0", hash_count); end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_hit();
    bit ok, to;
    int n_hs, se, s0;
    logic [31:0] exp_w[9];
    exp_w = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    hit_all = 1'b1; hit_sel = 1'b0; hit_hash = 256'd1; miss_hash = '1;
    s0 = start_cnt;
    load_header(20, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL hit_load got=%b exp=1", ok); end
    start_sweep(32'd5, 32'd5, '1);
    collect(1'b0, n_hs, se, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL hit_timeout got=%b exp=0", to); end
    checks++; if (n_hs !== 9) begin failures++; $display("FAIL hit_words got=%0d exp=9", n_hs); end
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL hit_core_starts got=%0d exp=1", start_cnt - s0); end
    checks++; if (cur_nonce !== 32'd5) begin failures++; $display("FAIL hit_hdr_nonce got=%h exp=00000005", cur_nonce); end
    checks++; if (hdr_w0 !== 32'd0 || hdr_w18 !== 32'd18) begin failures++; $display("FAIL hit_hdr_words got=%h/%h exp=00000000/00000012", hdr_w0, hdr_w18); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got_data[i] !== exp_w[i] || got_last[i] !== (i == 8)) begin
        failures++;
        $display("FAIL hit_word%0d got=%h last=%b exp=%h last=%b", i, got_data[i], got_last[i], exp_w[i], (i == 8));
      end
    end
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hit_idle busy=%b in_ready=%b exp=0/1", busy, in_ready); end
  endtask

  task automatic test_miss_sweep();
    bit ok;
    int s0, l0, e0, v0;
    hit_all = 1'b0; hit_sel = 1'b0; miss_hash = 256'd1;
    s0 = start_cnt; l0 = nonce_log.size(); e0 = exh_cnt; v0 = ov_cnt;
    load_header(20, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL miss_load got=%b exp=1", ok); end
    start_sweep(32'd0, 32'd3, 256'd0);
    for (int c = 0; c < 200 && exh_cnt == e0; c++) begin
      @(negedge clk);
      #1;
    end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL miss_idle busy=%b in_ready=%b exp=0/1", busy, in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (exh_cnt - e0 !== 1) begin failures++; $display("FAIL miss_exhausted_pulses got=%0d exp=1", exh_cnt - e0); end
    checks++; if (start_cnt - s0 !== 4) begin failures++; $display("FAIL miss_core_starts got=%0d exp=4", start_cnt - s0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nonce_log.size() <= l0 + i || nonce_log[l0+i] !== 32'(i)) begin
        failures++;
        $display("FAIL miss_nonce%0d got=%h exp=%h", i, (nonce_log.size() > l0 + i) ? nonce_log[l0+i] : 32'hDEAD_BEEF, 32'(i));
      end
    end
    checks++; if (ov_cnt - v0 !== 0) begin failures++; $display("FAIL miss_out_valid got=%0d exp=0", ov_cnt - v0); end
  endtask

  task automatic test_wrap();
    bit ok, to;
    int n_hs, se, l0;
    logic [31:0] exp_n[4];
    exp_n = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    hit_all = 1'b0; hit_sel = 1'b1; hit_nonce = 32'd1; hit_hash = 256'd1; miss_hash = '1;
    l0 = nonce_log.size();
    load_header(20, ok);
    start_sweep(32'hFFFF_FFFE, 32'h0000_0001, 256'h10);
    collect(1'b0, n_hs, se, to);
    checks++; if (to !== 1'b0 || n_hs !== 9) begin failures++; $display("FAIL wrap_words got=%0d timeout=%b exp=9/0", n_hs, to); end
    checks++; if (got_data[0] !== 32'd1) begin failures++; $display("FAIL wrap_first_word got=%h exp=00000001", got_data[0]); end
    checks++; if (nonce_log.size() - l0 !== 4) begin failures++; $display("FAIL wrap_tries got=%0d exp=4", nonce_log.size() - l0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nonce_log.size() <= l0 + i || nonce_log[l0+i] !== exp_n[i]) begin
        failures++;
        $display("FAIL wrap_nonce%0d got=%h exp=%h", i, (nonce_log.size() > l0 + i) ? nonce_log[l0+i] : 32'hDEAD_BEEF, exp_n[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, to;
    int n_hs, se;
    hit_all = 1'b1; hit_sel = 1'b0;
    hit_hash = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    load_header(20, ok);
    start_sweep(32'd7, 32'd7, '1);
    collect(1'b1, n_hs, se, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%b exp=0", to); end
    checks++; if (n_hs !== 9) begin failures++; $display("FAIL bp_handshakes got=%0d exp=9", n_hs); end
    checks++; if (se !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", se); end
    checks++; if (got_data[0] !== 32'd7) begin failures++; $display("FAIL bp_word0 got=%h exp=00000007", got_data[0]); end
    for (int i = 1; i < 9; i++) begin
      checks++;
      if (got_data[i] !== 32'h1111_1111 * i || got_last[i] !== (i == 8)) begin
        failures++;
        $display("FAIL bp_word%0d got=%h last=%b exp=%h last=%b", i, got_data[i], got_last[i], 32'h1111_1111 * i, (i == 8));
      end
    end
  endtask

  task automatic test_abort();
    bit ok, seen;
    int s0, e0, v0;
    hit_all = 1'b0; hit_sel = 1'b0; miss_hash = 256'd1;
    load_header(20, ok);
    e0 = exh_cnt; v0 = ov_cnt;
    start_sweep(32'd0, 32'd100, 256'd0);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (core_done) begin
        abort = 1'b1;
        seen = 1'b1;
      end
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL abort_core_done_seen got=%b exp=1", seen); end
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL abort_idle busy=%b in_ready=%b exp=0/1", busy, in_ready); end
    s0 = start_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (start_cnt !== s0) begin failures++; $display("FAIL abort_start_ignored got=%0d exp=%0d", start_cnt, s0); end
    checks++; if (exh_cnt - e0 !== 0 || ov_cnt - v0 !== 0) begin failures++; $display("FAIL abort_no_output exhausted=%0d valid=%0d exp=0/0", exh_cnt - e0, ov_cnt - v0); end
    load_header(19, ok);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_reload19 got=%b exp=1", in_ready); end
    load_header(1, ok);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_reload20 got=%b exp=0", in_ready); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

`ifdef MINER_STATS_EN
  task automatic test_stats();
    bit ok;
    int e0;
    hit_all = 1'b0; hit_sel = 1'b0; miss_hash = 256'd1;
    load_header(20, ok);
    e0 = exh_cnt;
    start_sweep(32'd100, 32'd109, 256'd0);
    for (int c = 0; c < 300 && exh_cnt == e0; c++) begin
      @(negedge clk);
      #1;
    end
    checks++; if (hash_count !== 32'd10) begin failures++; $display("FAIL stats_count got=%0d exp=10", hash_count); end
    load_header(20, ok);
    start_sweep(32'd0, 32'd0, 256'd0);
    #1;
    checks++; if (hash_count !== 32'd0) begin failures++; $display("FAIL stats_clear got=%0d exp=0", hash_count); end
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_miss_sweep();
    test_wrap();
    test_backpressure();
    test_abort();
`ifdef MINER_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
